// File: rtl/line_follow_drive.sv
// rtl/line_follow_drive.sv - line-follow drive core: sensor thresholding, follow/node/lost/done FSM, dual H-bridge PWM (optional PIVOT_TURN_EN)
module line_follow_drive #(
  parameter int NUM_SENS      = 3,
  parameter int ADC_W         = 12,
  parameter int THRESH        = 1000,
  parameter int PWM_W         = 8,
  parameter int BASE_DUTY     = 200,
  parameter int TURN_DUTY     = 80,
  parameter int NODE_DEBOUNCE = 4,
  parameter int MAX_NODES     = 10,
  parameter int NODE_CNT_W    = 4,
  parameter int LOST_TIMEOUT  = 64
) (
  input  logic                      clk_3125KHz,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_SENS*ADC_W-1:0] sens_data,
  input  logic                      sens_valid,
  output logic                      in1,
  output logic                      in2,
  output logic                      in3,
  output logic                      in4,
  output logic                      pwm_A,
  output logic                      pwm_B,
  output logic [NODE_CNT_W-1:0]     node_counter,
  output logic                      node_detected,
  output logic                      finish
);

  localparam int CEN    = NUM_SENS / 2;
  localparam int DEB_W  = $clog2(NODE_DEBOUNCE + 1);
  localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

  localparam logic [PWM_W-1:0]      BASE      = PWM_W'(BASE_DUTY);
  localparam logic [PWM_W-1:0]      TURN      = PWM_W'(TURN_DUTY);
  localparam logic [NODE_CNT_W-1:0] MAX_N     = NODE_CNT_W'(MAX_NODES);
  localparam logic [DEB_W-1:0]      DEB_LAST  = DEB_W'(NODE_DEBOUNCE - 1);
  localparam logic [LOST_W-1:0]     LOST_MAX  = LOST_W'(LOST_TIMEOUT);
  localparam logic [LOST_W-1:0]     LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
  // direction pin patterns packed as {in1, in2, in3, in4}
  localparam logic [3:0]            DIR_FWD   = 4'b1010;
  localparam logic [3:0]            DIR_STOP  = 4'b0000;

  typedef enum logic [2:0] {S_IDLE, S_FOLLOW, S_NODE, S_LOST, S_DONE} state_t;

  state_t                 state;
  logic [3:0]             dir_q;
  logic [PWM_W-1:0]       tgt_l, tgt_r;
  logic [PWM_W-1:0]       duty_a, duty_b;
  logic [PWM_W-1:0]       pwm_cnt;
  logic                   stopped;
  logic [DEB_W-1:0]       deb_cnt;
  logic [LOST_W-1:0]      lost_cnt;

  logic [NUM_SENS-1:0]    line;
  logic                   left_on, right_on, all_on, none_on;
  logic [3:0]             st_dir;
  logic [PWM_W-1:0]       st_dl, st_dr;

  assign {in1, in2, in3, in4} = dir_q;

  // Threshold each channel and derive the steering command for this sample
  always_comb begin
    line = '0;
    for (int i = 0; i < NUM_SENS; i++) begin
      line[i] = (sens_data[i*ADC_W +: ADC_W] > ADC_W'(THRESH));
    end
    left_on  = |line[NUM_SENS-1:CEN+1];
    right_on = |line[CEN-1:0];
    all_on   = &line;
    none_on  = ~|line;
    st_dir   = DIR_FWD;
    st_dl    = BASE;
    st_dr    = BASE;
    if (left_on && !right_on) begin
      st_dl = TURN;
    end else if (right_on && !left_on) begin
      st_dr = TURN;
    end
`ifdef PIVOT_TURN_EN
    // a lone outermost sensor spins the inner wheel backwards for a tighter turn
    if (line == {1'b1, {(NUM_SENS-1){1'b0}}}) begin
      st_dir = 4'b0110;
      st_dl  = TURN;
      st_dr  = BASE;
    end else if (line == NUM_SENS'(1)) begin
      st_dir = 4'b1001;
      st_dl  = BASE;
      st_dr  = TURN;
    end
`endif
  end

  // Drive FSM: registered direction pins, target duties, node/lost bookkeeping
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dir_q         <= DIR_STOP;
      tgt_l         <= '0;
      tgt_r         <= '0;
      stopped       <= 1'b1;
      node_counter  <= '0;
      node_detected <= 1'b0;
      finish        <= 1'b0;
      deb_cnt       <= '0;
      lost_cnt      <= '0;
    end else begin
      node_detected <= 1'b0;
      case (state)
        S_IDLE: begin
          dir_q   <= DIR_STOP;
          tgt_l   <= '0;
          tgt_r   <= '0;
          stopped <= 1'b1;
          if (start) begin
            node_counter <= '0;
            deb_cnt      <= '0;
            lost_cnt     <= '0;
            state        <= S_FOLLOW;
          end
        end
        S_FOLLOW: begin
          if (!start) begin
            state   <= S_IDLE;
            dir_q   <= DIR_STOP;
            tgt_l   <= '0;
            tgt_r   <= '0;
            stopped <= 1'b1;
          end else if (sens_valid) begin
            deb_cnt <= (all_on && deb_cnt != DEB_LAST) ? deb_cnt + 1'b1 : '0;
            if (none_on) begin
              // coast on the last command while the line is briefly out of view
              state    <= S_LOST;
              lost_cnt <= LOST_W'(1);
              if (LOST_TIMEOUT <= 1) begin
                dir_q   <= DIR_STOP;
                tgt_l   <= '0;
                tgt_r   <= '0;
                stopped <= 1'b1;
              end
            end else begin
              dir_q   <= st_dir;
              tgt_l   <= st_dl;
              tgt_r   <= st_dr;
              stopped <= 1'b0;
              if (all_on && deb_cnt == DEB_LAST) begin
                node_counter  <= (node_counter < MAX_N) ? node_counter + 1'b1 : node_counter;
                node_detected <= 1'b1;
                state         <= S_NODE;
              end
            end
          end
        end
        S_NODE: begin
          if (!start) begin
            state   <= S_IDLE;
            dir_q   <= DIR_STOP;
            tgt_l   <= '0;
            tgt_r   <= '0;
            stopped <= 1'b1;
          end else if (node_counter == MAX_N) begin
            state   <= S_DONE;
            finish  <= 1'b1;
            dir_q   <= DIR_STOP;
            tgt_l   <= '0;
            tgt_r   <= '0;
            stopped <= 1'b1;
          end else if (sens_valid && !all_on) begin
            // leaving the crossing re-arms the debounce so one node counts once
            state   <= S_FOLLOW;
            deb_cnt <= '0;
          end
        end
        S_LOST: begin
          if (!start) begin
            state   <= S_IDLE;
            dir_q   <= DIR_STOP;
            tgt_l   <= '0;
            tgt_r   <= '0;
            stopped <= 1'b1;
          end else if (sens_valid) begin
            if (none_on) begin
              if (lost_cnt != LOST_MAX) begin
                lost_cnt <= lost_cnt + 1'b1;
              end
              if (lost_cnt == LOST_LAST) begin
                dir_q   <= DIR_STOP;
                tgt_l   <= '0;
                tgt_r   <= '0;
                stopped <= 1'b1;
              end
            end else begin
              state    <= S_FOLLOW;
              lost_cnt <= '0;
              deb_cnt  <= '0;
              dir_q    <= st_dir;
              tgt_l    <= st_dl;
              tgt_r    <= st_dr;
              stopped  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          finish  <= 1'b1;
          dir_q   <= DIR_STOP;
          tgt_l   <= '0;
          tgt_r   <= '0;
          stopped <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running PWM; duties change only at the period boundary unless stopping
  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_a  <= '0;
      duty_b  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (stopped) begin
        duty_a <= '0;
        duty_b <= '0;
      end else if (pwm_cnt == '1) begin
        duty_a <= tgt_l;
        duty_b <= tgt_r;
      end
    end
  end

  // stopped masks the outputs in the same cycle the stop is commanded
  assign pwm_A = ~stopped & (pwm_cnt < duty_a);
  assign pwm_B = ~stopped & (pwm_cnt < duty_b);

endmodule

// File: tb/tb_line_follow_drive.sv
// tb/tb_line_follow_drive.sv - directed self-checking bench for line_follow_drive
module tb_line_follow_drive;

  logic        clk_3125KHz = 1'b0;
  logic        rst_n;
  logic        start;
  logic [35:0] sens_data;
  logic        sens_valid;
  logic        in1, in2, in3, in4;
  logic        pwm_A, pwm_B;
  logic [3:0]  node_counter;
  logic        node_detected;
  logic        finish;

  int checks   = 0;
  int failures = 0;

  line_follow_drive dut (
    .clk_3125KHz   (clk_3125KHz),
    .rst_n         (rst_n),
    .start         (start),
    .sens_data     (sens_data),
    .sens_valid    (sens_valid),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .in4           (in4),
    .pwm_A         (pwm_A),
    .pwm_B         (pwm_B),
    .node_counter  (node_counter),
    .node_detected (node_detected),
    .finish        (finish)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  function automatic logic [35:0] smp(input int c2, input int c1, input int c0);
    return {12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic send(input logic [35:0] d);
    sens_data  = d;
    sens_valid = 1'b1;
    tick();
    sens_valid = 1'b0;
  endtask

  task automatic pwm_window(output int ha, output int hb);
    ha = 0;
    hb = 0;
    repeat (260) tick();
    for (int k = 0; k < 256; k++) begin
      tick();
      ha += int'(pwm_A);
      hb += int'(pwm_B);
    end
  endtask

  function automatic logic [31:0] dir();
    return {28'd0, in1, in2, in3, in4};
  endfunction

  initial begin
    logic [35:0] cen_only, left_only, all_on, none_on;
    int ha, hb, extra;
    cen_only  = smp(200, 2000, 200);
    left_only = smp(2000, 200, 200);
    all_on    = smp(2000, 2000, 2000);
    none_on   = smp(200, 200, 200);
    rst_n = 1'b0; start = 1'b0; sens_valid = 1'b0; sens_data = '0;
    repeat (3) tick();
    check("rst_dir", dir(), 0);
    check("rst_pwm", {30'd0, pwm_A, pwm_B}, 0);
    check("rst_cnt", node_counter, 0);
    check("rst_pulse", node_detected, 0);
    check("rst_finish", finish, 0);

    rst_n = 1'b1; start = 1'b1;
    tick();
    send(cen_only);
    check("fwd_dir", dir(), 4'b1010);
    pwm_window(ha, hb);
    check("fwd_pwm_a", ha, 200);
    check("fwd_pwm_b", hb, 200);

    send(left_only);
`ifdef PIVOT_TURN_EN
    check("left_dir", dir(), 4'b0110);
`else
    check("left_dir", dir(), 4'b1010);
`endif
    pwm_window(ha, hb);
    check("left_pwm_a", ha, 80);
    check("left_pwm_b", hb, 200);

    send(smp(1000, 1001, 1000));
    check("thresh_dir", dir(), 4'b1010);
    pwm_window(ha, hb);
    check("thresh_pwm_a", ha, 200);
    check("thresh_pwm_b", hb, 200);

    extra = 0;
    repeat (3) begin send(all_on); extra += int'(node_detected); end
    send(cen_only);
    repeat (3) begin send(all_on); extra += int'(node_detected); end
    check("no_early_node", extra, 0);
    check("cnt_before", node_counter, 0);
    send(all_on);
    check("node_pulse", node_detected, 1);
    check("node_cnt1", node_counter, 1);
    tick();
    check("pulse_width", node_detected, 0);
    extra = 0;
    repeat (5) begin send(all_on); extra += int'(node_detected); end
    check("no_recount", extra, 0);
    check("node_cnt_hold", node_counter, 1);
    send(cen_only);
    repeat (2) begin
      repeat (4) send(all_on);
      send(cen_only);
    end
    check("node_cnt3", node_counter, 3);

    start = 1'b0;
    tick();
    check("idle_dir", dir(), 0);
    check("idle_pwm", {30'd0, pwm_A, pwm_B}, 0);
    check("idle_cnt", node_counter, 3);
    check("idle_finish", finish, 0);
    pwm_window(ha, hb);
    check("idle_pwm_window", ha + hb, 0);
    start = 1'b1;
    tick();
    check("restart_cnt", node_counter, 0);

    send(cen_only);
    repeat (63) send(none_on);
    check("lost_coast_dir", dir(), 4'b1010);
    check("lost_coast_pwm", pwm_A, 1'b1 & pwm_A);
    send(none_on);
    check("lost_stop_dir", dir(), 0);
    check("lost_stop_pwm", {30'd0, pwm_A, pwm_B}, 0);
    send(cen_only);
    check("resume_dir", dir(), 4'b1010);
    pwm_window(ha, hb);
    check("resume_pwm_a", ha, 200);
    check("resume_pwm_b", hb, 200);

    for (int k = 1; k <= 10; k++) begin
      repeat (4) send(all_on);
      if (k < 10) send(cen_only);
    end
    check("cnt_max", node_counter, 10);
    check("last_pulse", node_detected, 1);
    check("pre_done_finish", finish, 0);
    tick();
    check("done_finish", finish, 1);
    check("done_dir", dir(), 0);
    check("done_pwm", {30'd0, pwm_A, pwm_B}, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    send(all_on);
    send(cen_only);
    check("done_hold_finish", finish, 1);
    check("done_hold_dir", dir(), 0);
    check("done_hold_cnt", node_counter, 10);
    rst_n = 1'b0;
    tick();
    check("rst2_finish", finish, 0);
    check("rst2_cnt", node_counter, 0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
